sum_display: RTL
================

SUM_DISPLAY -- requirements
Module: sum_display

Interface
REQ-001 The block SHALL have parameter SCAN_DIV, default 4, giving clock cycles each display digit is held (legal range 2..65535).
REQ-002 The block SHALL have port CLK  input  1  single system clock; all state updates on its rising edge.
REQ-003 The block SHALL have port RST  input  1  asynchronous, active-high reset.
REQ-004 The block SHALL have port Sum  input  5  unsigned binary value to display (0..31), sampled only on an accepted Load.
REQ-005 The block SHALL have port Load  input  1  request to convert Sum; honoured only in IDLE.
REQ-006 The block SHALL have port Busy  output  1  high while a conversion is in progress (state CONV).
REQ-007 The block SHALL have port Done  output  1  one-cycle pulse when Tens/Ones have been updated.
REQ-008 The block SHALL have port Tens  output  4  BCD tens digit of last converted Sum (0..3).
REQ-009 The block SHALL have port Ones  output  4  BCD ones digit of last converted Sum (0..9).
REQ-010 The block SHALL have port An  output  2  one-hot digit select; 01 = ones digit, 10 = tens digit.
REQ-011 The block SHALL have port Seg  output  7  active-high segments {g,f,e,d,c,b,a} of the selected digit.
REQ-012 The block SHALL have port Dec  output  10  one-hot decimal of the selected digit; bit n set for digit value n.

Function
REQ-013 The controller SHALL have exactly two states: IDLE and CONV; all outputs SHALL be registered.
REQ-014 In IDLE with Load=1 at a clock edge: capture Sum into a 5-bit work register, clear a 2-bit tens counter, enter CONV.
REQ-015 In IDLE with Load=0: remain in IDLE; Tens/Ones hold.
REQ-016 In CONV, each edge with work>=10: work <= work-10, tens counter +1, stay in CONV.
REQ-017 In CONV, on the first edge with work<10: Ones <= work[3:0], Tens <= {2'b00, tens counter}, Done=1 for exactly one cycle, return to IDLE.
REQ-018 Latency: Done SHALL assert floor(Sum/10)+1 edges after the Load-accepting edge (1 for 0..9, 2 for 10..19, 3 for 20..29, 4 for 30..31).
REQ-019 Load asserted while in CONV SHALL be ignored; Sum changes during CONV SHALL not affect the result.
REQ-020 Load asserted in the cycle Done is high SHALL be accepted (state already IDLE), giving back-to-back conversions.
REQ-021 Busy SHALL equal (state==CONV); Done and Busy SHALL never be high in the same cycle.
REQ-022 Scan counter SHALL count 0..SCAN_DIV-1 continuously, independent of conversion; on wrap to 0, An SHALL toggle between 01 and 10.
REQ-023 Seg SHALL be the standard 7-segment code of the selected digit (0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111).
REQ-024 Leading-zero blanking: when An=10 and Tens=0, Seg SHALL be 0000000 and Dec SHALL be all zeros.
REQ-025 Seg/Dec SHALL reflect new Tens/Ones from the cycle after Done at the latest; no glitch states are permitted on registered outputs.

Reset
REQ-026 RST=1 SHALL asynchronously force: state IDLE, Busy=0, Done=0, Tens=0, Ones=0, work=0, tens counter=0, scan counter=0, An=01, Seg=0111111, Dec=0000000001.
REQ-027 RST asserted mid-conversion SHALL abort it with no Done pulse; Load is not honoured until the first edge after RST deasserts.

Verification
REQ-028 Reset: RST pulse mid-cycle -> outputs take REQ-026 values immediately, without waiting for CLK.
REQ-029 Sum=7, Load 1 cycle -> Done 1 edge later, Tens=0, Ones=7; An=10 phase shows Seg=0000000, Dec=0.
REQ-030 Sum=18 then Sum=31 back-to-back (second Load in Done cycle) -> Tens=1/Ones=8 after 2 edges, then Tens=3/Ones=1 after 4 more edges.
REQ-031 Sum=20, Load held high and Sum changed to 5 during CONV -> single conversion, Tens=2, Ones=0, no retrigger until IDLE.
REQ-032 SCAN_DIV=4, Tens=1, Ones=9 -> An alternates every 4 cycles; Seg 1101111/Dec bit9 on 01, Seg 0000110/Dec bit1 on 10.
REQ-033 Sum=25, RST asserted 2 edges after Load -> no Done, Tens/Ones=0; after release, Load with Sum=25 gives Tens=2, Ones=5 in 3 edges.

Source files
------------

// File: rtl/sum_display.sv
// Binary-to-BCD converter for a 0..31 sum (repeated subtract-10) driving a
// two-digit multiplexed 7-segment / one-hot decimal display.
module sum_display #(
  parameter int SCAN_DIV = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [4:0] Sum,
  input  logic       Load,
  output logic       Busy,
  output logic       Done,
  output logic [3:0] Tens,
  output logic [3:0] Ones,
  output logic [1:0] An,
  output logic [6:0] Seg,
  output logic [9:0] Dec
);

  // state | meaning
  // IDLE  | waiting for Load; Tens/Ones hold the last result
  // CONV  | subtracting 10 from work each cycle until work < 10
  typedef enum logic {IDLE, CONV} state_t;

  localparam logic [15:0] SCAN_LAST = 16'(SCAN_DIV - 1);

  state_t      r_state;
  logic [4:0]  r_work;
  logic [1:0]  r_tcnt;
  logic [15:0] r_scan;

  logic        w_fin;
  logic        w_scan_wrap;
  logic [3:0]  w_tens_nxt;
  logic [3:0]  w_ones_nxt;
  logic [1:0]  w_an_nxt;
  logic [3:0]  w_digit;
  logic        w_blank;
  logic [6:0]  w_seg_nxt;
  logic [9:0]  w_dec_nxt;

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    seg_code = 7'b0111111;
      4'd1:    seg_code = 7'b0000110;
      4'd2:    seg_code = 7'b1011011;
      4'd3:    seg_code = 7'b1001111;
      4'd4:    seg_code = 7'b1100110;
      4'd5:    seg_code = 7'b1101101;
      4'd6:    seg_code = 7'b1111101;
      4'd7:    seg_code = 7'b0000111;
      4'd8:    seg_code = 7'b1111111;
      4'd9:    seg_code = 7'b1101111;
      default: seg_code = 7'b0000000;
    endcase
  endfunction

  // Seg/Dec are decoded from the next-cycle digit values so they update on
  // the same edge as Tens/Ones/An and never show a stale combination.
  always_comb begin
    w_fin       = (r_state == CONV) && (r_work < 5'd10);
    w_tens_nxt  = w_fin ? {2'b00, r_tcnt} : Tens;
    w_ones_nxt  = w_fin ? r_work[3:0] : Ones;
    w_scan_wrap = (r_scan == SCAN_LAST);
    w_an_nxt    = w_scan_wrap ? ~An : An;
    w_digit     = w_an_nxt[1] ? w_tens_nxt : w_ones_nxt;
    w_blank     = w_an_nxt[1] && (w_tens_nxt == 4'd0);
    w_seg_nxt   = w_blank ? 7'b0000000 : seg_code(w_digit);
    w_dec_nxt   = 10'b0;
    if (!w_blank && (w_digit <= 4'd9))
      w_dec_nxt = 10'b1 << w_digit;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= IDLE;
      r_work  <= 5'd0;
      r_tcnt  <= 2'd0;
      r_scan  <= 16'd0;
      Busy    <= 1'b0;
      Done    <= 1'b0;
      Tens    <= 4'd0;
      Ones    <= 4'd0;
      An      <= 2'b01;
      Seg     <= 7'b0111111;
      Dec     <= 10'b0000000001;
    end else begin
      Done   <= 1'b0;
      r_scan <= w_scan_wrap ? 16'd0 : r_scan + 16'd1;
      An     <= w_an_nxt;
      Seg    <= w_seg_nxt;
      Dec    <= w_dec_nxt;
      Tens   <= w_tens_nxt;
      Ones   <= w_ones_nxt;
      case (r_state)
        IDLE: begin
          if (Load) begin
            r_work  <= Sum;
            r_tcnt  <= 2'd0;
            r_state <= CONV;
            Busy    <= 1'b1;
          end
        end
        CONV: begin
          if (!w_fin) begin
            r_work <= r_work - 5'd10;
            r_tcnt <= r_tcnt + 2'd1;
          end else begin
            Done    <= 1'b1;
            Busy    <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
